// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM; define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes
module mips_multicycle_control #(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       ExtendSign,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_I_WB      = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP    = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_t state_q;
    state_t state_d;
    logic   mem_ok;

    // funct is decoded by the downstream ALU control block, not here
    logic   funct_unused;
    assign funct_unused = ^funct;

    // Without the handshake every memory access completes in one cycle
    assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state  = state_q;

    // State register; reset aborts any instruction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; reset forces every strobe low at once
    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        ExtendSign  = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR load and PC+4 happen only on the cycle the fetch completes
                IRWrite = mem_ok;
                PCWrite = mem_ok;
                state_d = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ExtendSign = 1'b1;
                case (opcode)
                    OP_RTYPE:                         state_d = S_EXEC_R;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ExtendSign = 1'b1;
                if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ok ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_ok ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                ExtendSign  = 1'b1;
                PCWriteCond = (opcode == OP_BNE) ? ~zero : zero;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // Arithmetic immediates sign-extend; logical ones zero-extend
                case (opcode)
                    OP_ADDI: begin
                        ALUOp      = 2'b00;
                        ExtendSign = 1'b1;
                    end
                    OP_SLTI: begin
                        ALUOp      = 2'b01;
                        ExtendSign = 1'b1;
                    end
                    default: begin
                        ALUOp      = 2'b11;
                        ExtendSign = 1'b0;
                    end
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            ExtendSign  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - self-checking bench for mips_multicycle_control
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ILL   = 6'b111111;

    localparam int K_CYC  = 0;
    localparam int K_MEMW = 1;
    localparam int K_PCW  = 2;
    localparam int K_PCWC = 3;
    localparam int K_RWM  = 4;
    localparam int K_EXT2 = 5;
    localparam int K_EXTI = 6;
    localparam int K_AOPI = 7;
    localparam int K_PS1  = 8;
    localparam int K_FET  = 9;
    localparam int K_TRAP = 10;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, mtr, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic       ext;
    } outs_t;

    typedef struct {
        int   st;
        logic mr;
    } ph_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opcode, funct;
    logic zero, mem_ready;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA, ExtendSign;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    outs_t dut_o;
    outs_t exp_outs;
    logic [3:0] exp_state;
    logic exp_valid;

    int total = 0;
    int bad = 0;
    int win_id = 0, win_seen = 0;
    int req_id = 0, req_done = 0, req_kind = 0, req_exp = 0;
    string req_name = "";
    int c_nf = 0, c_fi = 0, c_f = 0, c_mw = 0, c_pcw = 0, c_pcwc = 0;
    int c_rwm = 0, c_ext2 = 0, c_exti = 0, c_aopi = 0, c_ps1 = 0, c_t = 0;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .ExtendSign(ExtendSign), .state(state)
    );

    assign dut_o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, ExtendSign};

    always #5 clk = ~clk;

    // What each named step of an instruction must present on the datapath
    function automatic outs_t model_out(int st, logic [5:0] opc, logic z, logic mr);
        outs_t o;
        o = '0;
        case (st)
            0:  begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
            1:  begin o.asb = 2'b11; o.ext = 1; end
            2:  begin o.asa = 1; o.asb = 2'b10; o.ext = 1; end
            3:  begin o.mrd = 1; o.iord = 1; end
            4:  begin o.rw = 1; o.mtr = 1; end
            5:  begin o.mwr = 1; o.iord = 1; end
            6:  begin o.asa = 1; o.aop = 2'b10; end
            7:  begin o.rw = 1; o.rdst = 1; end
            8:  begin
                    o.asa = 1; o.aop = 2'b01; o.pcs = 2'b01; o.ext = 1;
                    o.pcwc = (opc == OP_BNE) ? ~z : z;
                end
            9:  begin o.pcw = 1; o.pcs = 2'b10; end
            10: begin
                    o.asa = 1; o.asb = 2'b10;
                    if (opc == OP_ADDI)      begin o.aop = 2'b00; o.ext = 1; end
                    else if (opc == OP_SLTI) begin o.aop = 2'b01; o.ext = 1; end
                    else                     begin o.aop = 2'b11; o.ext = 0; end
                end
            11: begin o.rw = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Single per-cycle checker plus literal-count checks requested by the stimulus
    always @(negedge clk) begin : compare
        int n_chk, n_bad, act;
        bit nw, v;
        n_chk = 0;
        n_bad = 0;
        if (req_id != req_done) begin
            case (req_kind)
                K_CYC:  act = c_nf + c_fi;
                K_MEMW: act = c_mw;
                K_PCW:  act = c_pcw;
                K_PCWC: act = c_pcwc;
                K_RWM:  act = c_rwm;
                K_EXT2: act = c_ext2;
                K_EXTI: act = c_exti;
                K_AOPI: act = c_aopi;
                K_PS1:  act = c_ps1;
                K_FET:  act = c_f;
                default: act = c_t;
            endcase
            n_chk++;
            if (act != req_exp) begin
                n_bad++;
                $display("FAIL %s: got %0d want %0d", req_name, act, req_exp);
            end
        end
        req_done <= req_id;
        nw = (win_id != win_seen);
        win_seen <= win_id;
        v = exp_valid;
        if (v) begin
            n_chk++;
            if (state !== exp_state || dut_o !== exp_outs) begin
                n_bad++;
                $display("FAIL cycle t=%0t op=%b: state got %0d want %0d, outs got %h want %h",
                         $time, opcode, state, exp_state, dut_o, exp_outs);
            end
        end
        c_nf   <= (nw ? 0 : c_nf)   + int'(v && state != 4'd0);
        c_fi   <= (nw ? 0 : c_fi)   + int'(v && state == 4'd0 && IRWrite);
        c_f    <= (nw ? 0 : c_f)    + int'(v && state == 4'd0);
        c_mw   <= (nw ? 0 : c_mw)   + int'(v && MemWrite);
        c_pcw  <= (nw ? 0 : c_pcw)  + int'(v && PCWrite);
        c_pcwc <= (nw ? 0 : c_pcwc) + int'(v && PCWriteCond);
        c_rwm  <= (nw ? 0 : c_rwm)  + int'(v && RegWrite && MemtoReg);
        c_ext2 <= (nw ? 0 : c_ext2) + int'(v && state == 4'd2 && ExtendSign);
        c_exti <= (nw ? 0 : c_exti) + int'(v && state == 4'd10 && ExtendSign);
        c_ps1  <= (nw ? 0 : c_ps1)  + int'(v && PCSource == 2'b01);
        c_t    <= (nw ? 0 : c_t)    + int'(v && state == 4'd12);
        c_aopi <= (v && state == 4'd10) ? int'(ALUOp) : (nw ? 0 : c_aopi);
        total  <= total + n_chk;
        bad    <= bad + n_bad;
    end

    task automatic step(int st, logic [5:0] opc, logic z, logic mr);
        opcode    = opc;
        zero      = z;
        mem_ready = mr;
        exp_state = st[3:0];
        exp_outs  = model_out(st, opc, z, mr);
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        exp_state = 4'd0;
        exp_outs  = '0;
        exp_valid = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Expand an instruction into its sequence of steps, stretched by memory stalls
    task automatic run_instr(logic [5:0] opc, logic z, int fstall, int mstall);
        ph_t q[$];
        q = {};
        for (int i = 0; i < fstall; i++) q.push_back(ph_t'{0, 1'b0});
        q.push_back(ph_t'{0, 1'b1});
        q.push_back(ph_t'{1, 1'b1});
        case (opc)
            OP_RTYPE: begin q.push_back(ph_t'{6, 1'b1}); q.push_back(ph_t'{7, 1'b1}); end
            OP_LW: begin
                q.push_back(ph_t'{2, 1'b1});
                for (int i = 0; i < mstall; i++) q.push_back(ph_t'{3, 1'b0});
                q.push_back(ph_t'{3, 1'b1});
                q.push_back(ph_t'{4, 1'b1});
            end
            OP_SW: begin
                q.push_back(ph_t'{2, 1'b1});
                for (int i = 0; i < mstall; i++) q.push_back(ph_t'{5, 1'b0});
                q.push_back(ph_t'{5, 1'b1});
            end
            OP_BEQ, OP_BNE: q.push_back(ph_t'{8, 1'b1});
            OP_J: q.push_back(ph_t'{9, 1'b1});
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                q.push_back(ph_t'{10, 1'b1});
                q.push_back(ph_t'{11, 1'b1});
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++) q.push_back(ph_t'{12, 1'b1});
`endif
            end
        endcase
        win_id++;
        foreach (q[i]) step(q[i].st, opc, z, q[i].mr);
    endtask

    // Post one literal expectation; DUT idles in FETCH (mem_ready low) meanwhile
    task automatic lit(int kind, string name, int expv);
        exp_valid = 1'b0;
        mem_ready = 1'b0;
        req_kind  = kind;
        req_name  = name;
        req_exp   = expv;
        req_id++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'd0;
        funct     = 6'h20;
        zero      = 1'b0;
        mem_ready = 1'b1;
        exp_state = 4'd0;
        exp_outs  = '0;
        exp_valid = 1'b1;
        #1;
        reset_cycle();
        reset_cycle();
        reset = 1'b0;

        run_instr(OP_LW, 1'b0, 0, 0);
        lit(K_CYC,  "lw_cycles", 5);
        lit(K_RWM,  "lw_regwrite_memtoreg", 1);
        lit(K_EXT2, "lw_extendsign_memaddr", 1);

        run_instr(OP_ANDI, 1'b0, 0, 0);
        lit(K_CYC,  "andi_cycles", 4);
        lit(K_EXTI, "andi_extendsign", 0);
        lit(K_AOPI, "andi_aluop", 3);

        run_instr(OP_ADDI, 1'b0, 0, 0);
        lit(K_CYC,  "addi_cycles", 4);
        lit(K_EXTI, "addi_extendsign", 1);
        lit(K_AOPI, "addi_aluop", 0);

        run_instr(OP_BEQ, 1'b1, 0, 0);
        lit(K_CYC,  "beq_cycles", 3);
        lit(K_PCWC, "beq_z1_pcwritecond", 1);
        lit(K_PS1,  "beq_pcsource01", 1);

        run_instr(OP_BNE, 1'b1, 0, 0);
        lit(K_PCWC, "bne_z1_pcwritecond", 0);
        lit(K_PS1,  "bne_pcsource01", 1);

        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_BNE, 1'b0, 0, 0);
        lit(K_PCWC, "bne_z0_pcwritecond", 1);

        funct = 6'h22;
        run_instr(OP_RTYPE, 1'b0, 0, 0);
        lit(K_CYC, "rtype_cycles", 4);
        run_instr(OP_J, 1'b0, 0, 0);
        lit(K_CYC, "j_cycles", 3);
        run_instr(OP_SLTI, 1'b0, 0, 0);
        lit(K_AOPI, "slti_aluop", 1);
        run_instr(OP_ORI, 1'b0, 0, 0);
        lit(K_EXTI, "ori_extendsign", 0);

        run_instr(OP_SW, 1'b0, 0, 3);
        lit(K_CYC,  "sw_stall3_cycles", 7);
        lit(K_MEMW, "sw_stall3_memwrite", 4);

        run_instr(OP_SW, 1'b0, 2, 0);
        lit(K_PCW, "fetch_stall2_pcwrite", 1);
        lit(K_FET, "fetch_stall2_fetch_cycles", 3);
        lit(K_CYC, "sw_cycles", 4);

        run_instr(OP_LW, 1'b0, 1, 2);
        lit(K_CYC, "lw_mstall2_cycles", 7);

        // Reset arrives mid-cycle during a pending MEM_READ wait
        win_id++;
        step(0, OP_LW, 1'b0, 1'b1);
        step(1, OP_LW, 1'b0, 1'b1);
        step(2, OP_LW, 1'b0, 1'b1);
        step(3, OP_LW, 1'b0, 1'b0);
        exp_state = 4'd0;
        exp_outs  = '0;
        exp_valid = 1'b1;
        mem_ready = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset_cycle();
        reset = 1'b0;

        run_instr(OP_LW, 1'b0, 0, 0);
        lit(K_CYC, "lw_after_abort_cycles", 5);

        run_instr(OP_ILL, 1'b0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        lit(K_TRAP, "illegal_trap_hold", 10);
`else
        lit(K_CYC, "illegal_noop_cycles", 2);
`endif
        reset_cycle();
        reset = 1'b0;
        run_instr(OP_ADDI, 1'b0, 0, 0);
        lit(K_CYC, "addi_after_illegal_cycles", 4);

        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
